zhiwen_trigger: RTL and testbench
=================================

Name: zhiwen_trigger

Overview:
- Sequential fingerprint-capture trigger. Qualifies the touch-sensor input with a synchronizer and a hold-time (settle) counter, then raises tx_en toward the fingerprint transmit path.
- Waits for an acknowledge, retries on timeout and reports failure after exhausting retries.
- Sits between the touch sensor/control FSM (over_all, zhongzhi) and the fingerprint UART command sender.

Parameters:
- SETTLE_CYC, 50_000_000, cycles chumo must stay high before a send (1 s at 50 MHz)
- TIMEOUT_CYC, 25_000_000, cycles to wait for tx_ack per attempt
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(SETTLE_CYC, TIMEOUT_CYC)
- MAX_RETRY, 3, total send attempts before failure (>=1)
- RETRY_W, 2, width of retry_cnt; 2^RETRY_W > MAX_RETRY-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- chumo  in  1  raw touch-sensor level, asynchronous to clk
- over_all  in  1  global finish level; blocks and cancels triggering
- zhongzhi  in  1  forced-send level; highest priority
- tx_ack  in  1  one-cycle ack from the sender: command accepted and answered
- tx_en  out  1  registered send enable
- busy  out  1  high in SETTLE, SEND, GAP
- fail  out  1  sticky failure flag
- retry_cnt  out  RETRY_W  attempts already timed out in the current sequence

Behaviour:
- Reset: state=IDLE, tx_en=0, busy=0, fail=0, retry_cnt=0, counters=0, synchronizer flops=0.
- chumo passes through a 2-FF synchronizer to give chumo_s, with 2-cycle latency. All decisions use chumo_s.
- Per-cycle priority: zhongzhi > over_all > FSM.
- zhongzhi=1:
  - Next state is FORCE and tx_en=1 on the next edge.
  - Counters clear. fail and retry_cnt are unchanged.
  - On zhongzhi=0 in FORCE: go to IDLE with tx_en=0.
- over_all=1 (with zhongzhi=0):
  - Next state is IDLE, tx_en=0, counters clear.
  - The block stays in IDLE for as long as over_all is high, even if chumo_s=1.
- IDLE: tx_en=0. If chumo_s=1, go to SETTLE, clear cnt, clear fail and retry_cnt.
- SETTLE:
  - If chumo_s=0, go to IDLE (touch bounce or short touch).
  - Otherwise cnt increments.
  - When cnt==SETTLE_CYC-1, go to SEND and clear cnt.
  - tx_en therefore rises exactly SETTLE_CYC+1 cycles after chumo_s first samples high.
- SEND:
  - tx_en=1 and cnt counts.
  - tx_ack=1: go to DONE, tx_en=0 on the next edge.
  - cnt==TIMEOUT_CYC-1 with no ack:
    - If retry_cnt==MAX_RETRY-1, go to FAIL.
    - Otherwise retry_cnt+1 and go to GAP.
  - tx_ack arriving on the timeout cycle counts as success.
  - Releasing the finger in SEND does not abort the attempt.
- GAP: tx_en=0 for exactly one cycle, then SEND with cnt cleared. This creates a visible rising edge per attempt.
- DONE: tx_en=0. Stay until chumo_s=0, then go to IDLE. One touch gives at most one successful send.
- FAIL: tx_en=0, fail=1. Stay until chumo_s=0, then go to IDLE. fail stays high until the next SETTLE entry or reset.
- tx_ack outside SEND is ignored.
- Counters saturate logically by state exit and never wrap.

Optional Feature:
- Macro: ZHIWEN_RETRY_EN.
- Defined: retry behaviour as above; MAX_RETRY attempts, with a GAP between them.
- Undefined: MAX_RETRY is ignored, the first timeout goes straight to FAIL, GAP is unreachable, and retry_cnt is tied to 0.

Test Plan (SETTLE_CYC=8, TIMEOUT_CYC=16, MAX_RETRY=3, ZHIWEN_RETRY_EN defined):
- Reset check: assert rst mid-SEND → tx_en=0, fail=0, retry_cnt=0 immediately (asynchronous); after release, state is IDLE.
- Short touch: chumo high for 5 cycles → tx_en never asserts, busy drops within 3 cycles of chumo falling.
- Normal send:
  - Stimulus: chumo held high; tx_ack pulsed 4 cycles after tx_en rises.
  - Response: tx_en rises 11 cycles after chumo rises (2 sync + 9), falls the cycle after the ack, and stays 0 while chumo is held.
- Retry to failure:
  - Stimulus: chumo held high, no tx_ack.
  - Response: three tx_en pulses of 16 cycles each, separated by 1-cycle gaps; retry_cnt steps 0→1→2; then fail=1 and tx_en=0.
  - Release chumo → IDLE, fail remains 1 until the next touch.
- Over_all: over_all=1 during SEND → tx_en=0 next cycle. chumo held while over_all high → no trigger. over_all falls with chumo still high → SETTLE restarts and a send occurs 9 cycles later.
- Force: zhongzhi=1 while over_all=1 and idle → tx_en=1 next cycle. zhongzhi=0 → tx_en=0 next cycle, state IDLE.

Source files
------------

// File: rtl/zhiwen_trigger_if.sv
// Bundle of the touch/control inputs and transmit-path outputs of zhiwen_trigger.
// The master modport is the side that drives the sensor, control and ack levels.
// The slave modport is the trigger itself.
interface zhiwen_trigger_if #(
    parameter int RETRY_W = 2
);
    logic               chumo;
    logic               over_all;
    logic               zhongzhi;
    logic               tx_ack;
    logic               tx_en;
    logic               busy;
    logic               fail;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output chumo, over_all, zhongzhi, tx_ack,
        input  tx_en, busy, fail, retry_cnt
    );

    modport slave (
        input  chumo, over_all, zhongzhi, tx_ack,
        output tx_en, busy, fail, retry_cnt
    );
endinterface

// File: rtl/zhiwen_trigger.sv
// zhiwen_trigger: fingerprint-capture trigger.
// - A touch level is synchronized and must be held for SETTLE_CYC cycles.
// - tx_en is then raised toward the UART command sender until tx_ack arrives.
// - Each attempt times out after TIMEOUT_CYC cycles.
// Optional macro ZHIWEN_RETRY_EN: when defined, up to MAX_RETRY attempts are
// made, separated by a one-cycle gap. When undefined, the first timeout is
// terminal and retry_cnt stays 0.
//
// state  | meaning
// IDLE   | waiting for a synchronized touch
// SETTLE | touch held, counting hold time
// SEND   | tx_en high, waiting for tx_ack or timeout
// GAP    | one low cycle between attempts
// DONE   | send acknowledged, waiting for finger release
// FAIL   | all attempts timed out, waiting for finger release
// FORCE  | zhongzhi forcing tx_en high
module zhiwen_trigger #(
    parameter int SETTLE_CYC  = 50_000_000,
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int CNT_W       = 26,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    zhiwen_trigger_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SEND   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAIL   = 3'd5,
        ST_FORCE  = 3'd6
    } state_t;

`ifdef ZHIWEN_RETRY_EN
    localparam int unsigned LAST_TRY = MAX_RETRY - 1;
`else
    // MAX_RETRY has no effect here: the first timeout is always the last one.
    localparam int unsigned LAST_TRY = 0 * MAX_RETRY;
`endif

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(LAST_TRY);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               sync1_q, chumo_s_q;
    logic               tx_en_q, tx_en_d;
    logic               busy_q, busy_d;
    logic               fail_q, fail_d;

    // State register, counters, synchronizer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            sync1_q   <= 1'b0;
            chumo_s_q <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sync1_q   <= bus.chumo;
            chumo_s_q <= sync1_q;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            fail_q    <= fail_d;
        end
    end

    // Next state and counters: zhongzhi beats over_all, which beats the sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (bus.zhongzhi) begin
            state_d = ST_FORCE;
            cnt_d   = '0;
        end else if (bus.over_all) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (chumo_s_q) begin
                        state_d = ST_SETTLE;
                        retry_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (!chumo_s_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SEND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    // An ack on the timeout cycle still counts as success.
                    if (bus.tx_ack) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_GAP;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
                ST_DONE, ST_FAIL: begin
                    cnt_d = '0;
                    if (!chumo_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FORCE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the upcoming state so they register on the same edge.
    always_comb begin
        tx_en_d = (state_d == ST_SEND) || (state_d == ST_FORCE);
        busy_d  = (state_d == ST_SETTLE) || (state_d == ST_SEND) || (state_d == ST_GAP);
        fail_d  = fail_q;
        if (state_d == ST_FAIL) begin
            fail_d = 1'b1;
        end else if ((state_q == ST_IDLE) && (state_d == ST_SETTLE)) begin
            fail_d = 1'b0;
        end
    end

    assign bus.tx_en     = tx_en_q;
    assign bus.busy      = busy_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_zhiwen_trigger.sv
// Bench for zhiwen_trigger with short settle/timeout values. A behavioural
// model tracks touch phases cycle by cycle; directed scenarios are followed
// by a randomized run.
module tb_zhiwen_trigger;
    localparam int S  = 8;
    localparam int T  = 16;
    localparam int CW = 5;
    localparam int MR = 3;
    localparam int RW = 2;
`ifdef ZHIWEN_RETRY_EN
    localparam int ATTEMPTS = MR;
`else
    localparam int ATTEMPTS = 1;
`endif

    localparam int P_IDLE = 0, P_HOLD = 1, P_SEND = 2, P_GAP = 3,
                   P_DONE = 4, P_FAIL = 5, P_FORCE = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    zhiwen_trigger_if #(.RETRY_W(RW)) bus ();

    zhiwen_trigger #(
        .SETTLE_CYC (S),
        .TIMEOUT_CYC(T),
        .CNT_W      (CW),
        .MAX_RETRY  (MR),
        .RETRY_W    (RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: touch phase, time spent in the phase, timeouts so far.
    int m_phase, m_time, m_timeouts;
    bit m_fail, m_d1, m_d2;

    always @(posedge clk or posedge rst) begin
        bit touch;
        if (rst) begin
            m_phase = P_IDLE; m_time = 0; m_timeouts = 0;
            m_fail = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            touch = m_d2;
            m_d2  = m_d1;
            m_d1  = bus.chumo;
            if (bus.zhongzhi) begin
                m_phase = P_FORCE; m_time = 0;
            end else if (bus.over_all) begin
                m_phase = P_IDLE; m_time = 0;
            end else begin
                case (m_phase)
                    P_IDLE: if (touch) begin
                        m_phase = P_HOLD; m_time = 0; m_timeouts = 0; m_fail = 0;
                    end
                    P_HOLD: begin
                        m_time++;
                        if (!touch) begin
                            m_phase = P_IDLE; m_time = 0;
                        end else if (m_time == S) begin
                            m_phase = P_SEND; m_time = 0;
                        end
                    end
                    P_SEND: begin
                        m_time++;
                        if (bus.tx_ack) begin
                            m_phase = P_DONE; m_time = 0;
                        end else if (m_time == T) begin
                            m_time = 0;
                            if (m_timeouts + 1 >= ATTEMPTS) begin
                                m_phase = P_FAIL; m_fail = 1;
                            end else begin
                                m_timeouts++; m_phase = P_GAP;
                            end
                        end
                    end
                    P_GAP: m_phase = P_SEND;
                    P_DONE, P_FAIL: if (!touch) m_phase = P_IDLE;
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check_val("tx_en", bus.tx_en, (m_phase == P_SEND || m_phase == P_FORCE) ? 1 : 0);
        check_val("busy", bus.busy,
                  (m_phase == P_HOLD || m_phase == P_SEND || m_phase == P_GAP) ? 1 : 0);
        check_val("fail", bus.fail, m_fail);
        check_val("retry_cnt", bus.retry_cnt, m_timeouts);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tx_en && n < 40);
    endtask

    initial begin
        int n, len;
        int lens[$];
        bit seen;

        rst = 1'b1;
        bus.chumo = 0; bus.over_all = 0; bus.zhongzhi = 0; bus.tx_ack = 0;
        repeat (2) @(negedge clk);
        check_model();
        rst = 1'b0;
        step();

        // Short touch: five cycles never reach the settle count.
        seen = 0;
        bus.chumo = 1;
        repeat (5) begin step(); seen |= bus.tx_en; end
        bus.chumo = 0;
        n = 0;
        do begin step(); n++; seen |= bus.tx_en; end while (bus.busy && n < 10);
        check_val("short_no_tx", seen, 0);
        check_val("short_busy_drop", n, 3);
        repeat (3) step();

        // Normal send with ack four cycles after tx_en rises.
        bus.chumo = 1;
        wait_tx(n);
        check_val("send_latency", n, 2 + S + 1);
        repeat (3) step();
        bus.tx_ack = 1;
        step();
        bus.tx_ack = 0;
        check_val("ack_drop", bus.tx_en, 0);
        seen = 0;
        repeat (12) begin step(); seen |= bus.tx_en; end
        check_val("single_send", seen, 0);
        bus.chumo = 0;
        repeat (4) step();

        // Retry to failure: no ack at all.
        bus.chumo = 1;
        len = 0;
        repeat (80) begin
            step();
            if (bus.tx_en) len++;
            else if (len != 0) begin lens.push_back(len); len = 0; end
        end
        check_val("pulse_count", lens.size(), ATTEMPTS);
        foreach (lens[i]) check_val("pulse_len", lens[i], T);
        check_val("fail_set", bus.fail, 1);
        check_val("retry_final", bus.retry_cnt, ATTEMPTS - 1);
        bus.chumo = 0;
        repeat (5) step();
        check_val("fail_sticky", bus.fail, 1);
        bus.chumo = 1;
        repeat (4) step();
        check_val("fail_cleared", bus.fail, 0);
        bus.chumo = 0;
        repeat (4) step();

        // over_all cancels a send and blocks triggering while high.
        bus.chumo = 1;
        wait_tx(n);
        check_val("ov_pre_tx", bus.tx_en, 1);
        bus.over_all = 1;
        step();
        check_val("ov_cancel", bus.tx_en, 0);
        seen = 0;
        repeat (15) begin step(); seen |= bus.busy | bus.tx_en; end
        check_val("ov_block", seen, 0);
        bus.over_all = 0;
        wait_tx(n);
        check_val("ov_resume_latency", n, S + 1);
        bus.tx_ack = 1;
        step();
        bus.tx_ack = 0;
        bus.chumo = 0;
        repeat (4) step();

        // Forced send overrides over_all.
        bus.over_all = 1;
        bus.zhongzhi = 1;
        step();
        check_val("force_on", bus.tx_en, 1);
        bus.zhongzhi = 0;
        step();
        check_val("force_off", bus.tx_en, 0);
        bus.over_all = 0;
        repeat (2) step();

        // Asynchronous reset in the middle of a send sequence.
        bus.chumo = 1;
        wait_tx(n);
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        check_val("rst_tx_en", bus.tx_en, 0);
        check_val("rst_fail", bus.fail, 0);
        check_val("rst_retry", bus.retry_cnt, 0);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        bus.chumo = 0;
        repeat (3) step();
        check_val("rst_idle_busy", bus.busy, 0);

        // Randomized run against the model.
        repeat (700) begin
            if ($urandom_range(19) == 0) bus.chumo = ~bus.chumo;
            if (!bus.over_all && $urandom_range(59) == 0) bus.over_all = 1;
            else if (bus.over_all && $urandom_range(5) == 0) bus.over_all = 0;
            if (!bus.zhongzhi && $urandom_range(99) == 0) bus.zhongzhi = 1;
            else if (bus.zhongzhi && $urandom_range(2) == 0) bus.zhongzhi = 0;
            bus.tx_ack = ($urandom_range(11) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
